// File: rtl/reg_loader.sv
// reg_loader: streams bytes into consecutive register file entries, then reads them back and verifies
module reg_loader #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int NUM_REGS   = 8
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  START,
    input  logic [ADDR_WIDTH-1:0] BASEADDR,
    input  logic [ADDR_WIDTH:0]   COUNT,
    input  logic [DATA_WIDTH-1:0] DIN,
    input  logic                  DIN_VALID,
    output logic                  DIN_READY,
    output logic [DATA_WIDTH-1:0] REG_IN,
    output logic [ADDR_WIDTH-1:0] REG_INADDRESS,
    output logic                  REG_WRITE,
    output logic [ADDR_WIDTH-1:0] REG_OUTADDRESS,
    input  logic [DATA_WIDTH-1:0] REG_OUT,
    output logic                  BUSY,
    output logic                  DONE,
    output logic                  ERROR,
    output logic [ADDR_WIDTH-1:0] ERRADDR
);
    typedef enum logic [2:0] {IDLE, LOAD, DRAIN, VERIFY, FINISH} state_t;
    localparam logic [ADDR_WIDTH:0] MAX_COUNT = (ADDR_WIDTH+1)'(NUM_REGS);
    localparam logic [ADDR_WIDTH:0] ONE = (ADDR_WIDTH+1)'(1);
    state_t state;
    logic [ADDR_WIDTH-1:0] ptr, base, idx;
    logic [ADDR_WIDTH:0] remaining, total, count_clamped;
    logic [DATA_WIDTH-1:0] shadow [NUM_REGS];
    logic xfer;
    assign count_clamped = (COUNT > MAX_COUNT) ? MAX_COUNT : COUNT;
    assign DIN_READY = (state == LOAD);
    assign BUSY = (state != IDLE);
    assign DONE = (state == FINISH);
    assign xfer = DIN_READY && DIN_VALID;
    // keep a copy of every accepted byte for the read-back compare
    always_ff @(posedge CLK) begin
        if (xfer) shadow[idx] <= DIN;
    end
    // session sequencer: load, let the last write land, verify, report
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= IDLE;
            ptr <= '0;
            base <= '0;
            idx <= '0;
            remaining <= '0;
            total <= '0;
            REG_IN <= '0;
            REG_INADDRESS <= '0;
            REG_WRITE <= 1'b0;
            REG_OUTADDRESS <= '0;
            ERROR <= 1'b0;
            ERRADDR <= '0;
        end else begin
            case (state)
                IDLE: if (START) begin
                    ptr <= BASEADDR;
                    base <= BASEADDR;
                    idx <= '0;
                    remaining <= count_clamped;
                    total <= count_clamped;
                    ERROR <= 1'b0;
                    ERRADDR <= '0;
                    state <= (~|count_clamped) ? FINISH : LOAD;
                end
                LOAD: begin
                    REG_WRITE <= xfer;
                    if (xfer) begin
                        REG_IN <= DIN;
                        REG_INADDRESS <= ptr;
                        ptr <= ptr + 1'b1;
                        idx <= idx + 1'b1;
                        remaining <= remaining - 1'b1;
                        if (remaining == ONE) begin
                            ptr <= base;
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    REG_WRITE <= 1'b0;
                    REG_OUTADDRESS <= base;
                    idx <= '0;
                    remaining <= total;
                    state <= VERIFY;
                end
                VERIFY: if (REG_OUT != shadow[idx]) begin
                    ERROR <= 1'b1;
                    ERRADDR <= REG_OUTADDRESS;
                    state <= FINISH;
                end else begin
                    REG_OUTADDRESS <= REG_OUTADDRESS + 1'b1;
                    idx <= idx + 1'b1;
                    remaining <= remaining - 1'b1;
                    if (remaining == ONE) state <= FINISH;
                end
                FINISH: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_reg_loader.sv
// tb_reg_loader: randomized sessions against a register file model and an arithmetic reference
module tb_reg_loader;
    logic CLK = 1'b0;
    logic RESET, START, DIN_VALID, DIN_READY, REG_WRITE, BUSY, DONE, ERROR;
    logic [2:0] BASEADDR, REG_INADDRESS, REG_OUTADDRESS, ERRADDR;
    logic [3:0] COUNT;
    logic [7:0] DIN, REG_IN, REG_OUT;
    logic [7:0] rf [8];
    logic [7:0] mm [8];
    logic [7:0] mv;
    logic fault;
    logic [10:0] wq [$];
    int dones = 0, bad_wr = 0, passed = 0, total = 0;

    reg_loader dut (
        .CLK(CLK), .RESET(RESET), .START(START), .BASEADDR(BASEADDR), .COUNT(COUNT),
        .DIN(DIN), .DIN_VALID(DIN_VALID), .DIN_READY(DIN_READY), .REG_IN(REG_IN),
        .REG_INADDRESS(REG_INADDRESS), .REG_WRITE(REG_WRITE), .REG_OUTADDRESS(REG_OUTADDRESS),
        .REG_OUT(REG_OUT), .BUSY(BUSY), .DONE(DONE), .ERROR(ERROR), .ERRADDR(ERRADDR)
    );

    always #5 CLK = ~CLK;

    assign REG_OUT = (fault && REG_OUTADDRESS == 3'd2) ? 8'hFF : rf[REG_OUTADDRESS];

    always @(posedge CLK) begin
        if (REG_WRITE) begin
            rf[REG_INADDRESS] <= REG_IN;
            wq.push_back({REG_INADDRESS, REG_IN});
        end
        if (DONE) dones++;
        if (REG_WRITE && !BUSY) bad_wr++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    task automatic run(input logic [2:0] b, input logic [3:0] c, input int pct, input bit f, input bit noise);
        int n, sent, cyc, e, k, exp_e, w0, d0;
        logic [7:0] data [8];
        logic rdy;
        bit got_done;
        n = (c > 8) ? 8 : int'(c);
        for (int i = 0; i < 8; i++) data[i] = f ? 8'($urandom_range(254)) : 8'($urandom_range(255));
        k = -1;
        if (f) for (int i = 0; i < n; i++) if (k < 0 && ((b + i) % 8) == 2) k = i;
        w0 = wq.size();
        d0 = dones;
        @(negedge CLK);
        fault = f;
        START = 1'b1;
        BASEADDR = b;
        COUNT = c;
        @(posedge CLK);
        @(negedge CLK);
        START = 1'b0;
        BASEADDR = 3'($urandom);
        COUNT = 4'($urandom);
        chk("err_clear", ERROR, 0);
        chk("busy_start", BUSY, 1);
        sent = 0;
        cyc = 0;
        while (sent < n && cyc < 300) begin
            DIN = data[sent];
            DIN_VALID = ($urandom_range(99) < pct);
            START = noise && ($urandom_range(1) == 1);
            rdy = DIN_READY;
            @(posedge CLK);
            if (rdy && DIN_VALID) sent++;
            cyc++;
            @(negedge CLK);
        end
        START = 1'b0;
        DIN_VALID = 1'($urandom);
        chk("sent", sent, n);
        exp_e = (n == 0) ? 0 : (k >= 0 ? k + 2 : n + 1);
        e = 0;
        got_done = 0;
        while (!got_done && e < 40) begin
            if (DONE) got_done = 1;
            else begin
                @(posedge CLK);
                e++;
                @(negedge CLK);
            end
        end
        chk("done_seen", got_done, 1);
        chk("done_latency", e, exp_e);
        chk("error", ERROR, k >= 0);
        if (k >= 0) chk("erraddr", ERRADDR, 2);
        @(negedge CLK);
        chk("busy_end", BUSY, 0);
        chk("done_pulse", DONE, 0);
        chk("done_count", dones - d0, 1);
        chk("n_writes", wq.size() - w0, n);
        for (int i = 0; i < n; i++) begin
            if (w0 + i < wq.size()) chk("write", wq[w0 + i], {3'((b + i) % 8), data[i]});
            mm[(b + i) % 8] = data[i];
            mv[(b + i) % 8] = 1'b1;
        end
        for (int a = 0; a < 8; a++) if (mv[a]) chk("reg", rf[a], mm[a]);
        fault = 1'b0;
    endtask

    initial begin
        int w0, d0;
        logic [7:0] b0;
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int w0, d0;
        logic [7:0] b0;
        RESET = 1'b1;
        START = 1'b0;
        BASEADDR = '0;
        COUNT = '0;
        DIN = '0;
        DIN_VALID = 1'b0;
        fault = 1'b0;
        mv = '0;
        repeat (2) @(negedge CLK);
        chk("rst_ready", DIN_READY, 0);
        chk("rst_write", REG_WRITE, 0);
        chk("rst_in", REG_IN, 0);
        chk("rst_inaddr", REG_INADDRESS, 0);
        chk("rst_outaddr", REG_OUTADDRESS, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_done", DONE, 0);
        chk("rst_error", ERROR, 0);
        chk("rst_erraddr", ERRADDR, 0);
        RESET = 1'b0;
        run(3'd0, 4'd8, 100, 0, 0);
        run(3'd6, 4'd4, 100, 0, 0);
        run(3'd0, 4'd3, 50, 0, 1);
        run(3'd0, 4'd5, 100, 1, 0);
        run(3'd3, 4'd2, 100, 0, 0);
        run(3'd2, 4'd12, 100, 0, 0);
        run(3'd5, 4'd0, 100, 0, 1);
        w0 = wq.size();
        d0 = dones;
        b0 = 8'($urandom);
        @(negedge CLK);
        START = 1'b1;
        BASEADDR = 3'd1;
        COUNT = 4'd5;
        @(posedge CLK);
        @(negedge CLK);
        START = 1'b0;
        DIN = b0;
        DIN_VALID = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        DIN = 8'($urandom);
        @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b1;
        #1;
        chk("mid_rst_write", REG_WRITE, 0);
        chk("mid_rst_busy", BUSY, 0);
        chk("mid_rst_ready", DIN_READY, 0);
        chk("mid_rst_done", DONE, 0);
        DIN_VALID = 1'b0;
        repeat (3) @(negedge CLK);
        RESET = 1'b0;
        repeat (3) @(negedge CLK);
        chk("mid_rst_no_done", dones - d0, 0);
        chk("mid_rst_writes", wq.size() - w0, 1);
        mm[1] = b0;
        mv[1] = 1'b1;
        chk("mid_rst_reg", rf[1], b0);
        run(3'd1, 4'd5, 100, 0, 0);
        repeat (12) run(3'($urandom), 4'($urandom_range(15)), int'($urandom_range(100, 40)),
                        $urandom_range(1) == 1, 1);
        chk("no_stray_write", bad_wr, 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
